// File: rtl/frame_cmd_rx_if.sv
// Word stream in / frame RAM write port out for frame_cmd_rx.
//   frame_in        16      received word
//   frame_in_valid  1       word valid; one contiguous high run per frame
//   ram_wr_en       1       RAM write strobe
//   ram_wr_addr     ADDR_W  word index within the frame (0 = header)
//   ram_wr_data     16      word to write
// master: the side driving the word stream (deserializer / bench).
// slave:  the parser.
interface frame_cmd_rx_if #(
    parameter int unsigned ADDR_W = 10
);
    localparam int unsigned WORD_W = 16;

    logic [WORD_W-1:0] frame_in;
    logic              frame_in_valid;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [WORD_W-1:0] ram_wr_data;

    modport master (
        output frame_in, frame_in_valid,
        input  ram_wr_en, ram_wr_addr, ram_wr_data
    );

    modport slave (
        input  frame_in, frame_in_valid,
        output ram_wr_en, ram_wr_addr, ram_wr_data
    );
endinterface

// File: rtl/frame_cmd_rx.sv
// Receive-side command frame parser. Hunts for the header word, checks the
// frame length against FRAME_LEN, writes each accepted word into the frame
// RAM port and reports per-frame done/error status.
//   clk_rd      in   receive clock, all logic on its rising edge
//   FPGA_RESET  in   synchronous active-high reset
//   bus         slave modport: word stream in, RAM write port out
//   rx_busy     out  high while receiving or awaiting the end-of-frame gap
//   frame_done  out  one-cycle pulse, good frame committed
//   frame_err   out  one-cycle pulse, frame rejected
//   err_code    out  last rejection reason: 01 header, 10 short, 11 long
//   cmd_mode    out  word 1 of the last good frame
//   frame_cnt   out  good frame count (wraps)
//   err_cnt     out  rejected frame count (saturates)
module frame_cmd_rx #(
    parameter int unsigned FRAME_LEN = 181,
    parameter logic [15:0] HEADER    = 16'hABCD,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic                clk_rd,
    input  logic                FPGA_RESET,
    frame_cmd_rx_if.slave       bus,
    output logic                rx_busy,
    output logic                frame_done,
    output logic                frame_err,
    output logic [1:0]          err_code,
    output logic [15:0]         cmd_mode,
    output logic [15:0]         frame_cnt,
    output logic [15:0]         err_cnt
);
    localparam int unsigned WORD_W = 16;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
    localparam logic [1:0] ERR_HDR   = 2'b01;
    localparam logic [1:0] ERR_SHORT = 2'b10;
    localparam logic [1:0] ERR_LONG  = 2'b11;

    typedef enum logic [1:0] {IDLE, RECV, CHECK, DISCARD} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   cnt, cnt_n;
    logic [WORD_W-1:0]   shadow, shadow_n;
    logic                wr_en_n;
    logic [ADDR_W-1:0]   wr_addr_n;
    logic [WORD_W-1:0]   wr_data_n;
    logic                busy_n, done_n, err_n;
    logic [1:0]          err_code_n;
    logic [WORD_W-1:0]   cmd_mode_n, frame_cnt_n, err_cnt_n;

    // Next-state, RAM write and status decode.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shadow_n    = shadow;
        wr_en_n     = 1'b0;
        wr_addr_n   = cnt;
        wr_data_n   = bus.frame_in;
        done_n      = 1'b0;
        err_n       = 1'b0;
        err_code_n  = err_code;
        cmd_mode_n  = cmd_mode;
        frame_cnt_n = frame_cnt;

        unique case (state)
            IDLE: begin
                if (bus.frame_in_valid) begin
                    if (bus.frame_in == HEADER) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = '0;
                        cnt_n     = ADDR_W'(1);
                        state_n   = RECV;
                    end else begin
                        err_n      = 1'b1;
                        err_code_n = ERR_HDR;
                        state_n    = DISCARD;
                    end
                end
            end
            RECV: begin
                if (bus.frame_in_valid) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = cnt;
                    cnt_n     = cnt + ADDR_W'(1);
                    // Word 1 is the mode word; held until the frame proves good.
                    if (cnt == ADDR_W'(1)) begin
                        shadow_n = bus.frame_in;
                    end
                    if (cnt == LAST_IDX) begin
                        state_n = CHECK;
                    end
                end else begin
                    err_n      = 1'b1;
                    err_code_n = ERR_SHORT;
                    state_n    = IDLE;
                end
            end
            CHECK: begin
                // The valid-low gap after the last word is what proves the length.
                if (bus.frame_in_valid) begin
                    err_n      = 1'b1;
                    err_code_n = ERR_LONG;
                    state_n    = DISCARD;
                end else begin
                    done_n      = 1'b1;
                    cmd_mode_n  = shadow;
                    frame_cnt_n = frame_cnt + WORD_W'(1);
                    state_n     = IDLE;
                end
            end
            DISCARD: begin
                if (!bus.frame_in_valid) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        err_cnt_n = (err_n && (err_cnt != '1)) ? err_cnt + WORD_W'(1) : err_cnt;
        busy_n    = (state_n == RECV) || (state_n == CHECK);
    end

    // State and registered outputs.
    always_ff @(posedge clk_rd) begin
        if (FPGA_RESET) begin
            state           <= IDLE;
            cnt             <= '0;
            shadow          <= '0;
            bus.ram_wr_en   <= 1'b0;
            bus.ram_wr_addr <= '0;
            bus.ram_wr_data <= '0;
            rx_busy         <= 1'b0;
            frame_done      <= 1'b0;
            frame_err       <= 1'b0;
            err_code        <= '0;
            cmd_mode        <= '0;
            frame_cnt       <= '0;
            err_cnt         <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            shadow          <= shadow_n;
            bus.ram_wr_en   <= wr_en_n;
            bus.ram_wr_addr <= wr_addr_n;
            bus.ram_wr_data <= wr_data_n;
            rx_busy         <= busy_n;
            frame_done      <= done_n;
            frame_err       <= err_n;
            err_code        <= err_code_n;
            cmd_mode        <= cmd_mode_n;
            frame_cnt       <= frame_cnt_n;
            err_cnt         <= err_cnt_n;
        end
    end
endmodule

// File: tb/tb_frame_cmd_rx.sv
// Scoreboard bench for frame_cmd_rx: stimulus pushes expected RAM writes and
// status pulses (with the cycle they must appear) from a frame-level model;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_frame_cmd_rx;
    localparam int unsigned FRAME_LEN = 181;
    localparam int unsigned ADDR_W    = 10;
    localparam logic [15:0] HEADER    = 16'hABCD;

    typedef struct {
        int          addr;
        logic [15:0] data;
        int          stamp;
    } wr_exp_t;

    typedef struct {
        bit          is_done;
        logic [1:0]  code;
        logic [15:0] mode;
        logic [15:0] fcnt;
        logic [15:0] ecnt;
        int          stamp;
    } ev_exp_t;

    logic        clk_rd = 1'b0;
    logic        FPGA_RESET;
    logic        rx_busy, frame_done, frame_err;
    logic [1:0]  err_code;
    logic [15:0] cmd_mode, frame_cnt, err_cnt;

    frame_cmd_rx_if #(.ADDR_W(ADDR_W)) bus ();

    frame_cmd_rx #(.FRAME_LEN(FRAME_LEN), .HEADER(HEADER), .ADDR_W(ADDR_W)) dut (
        .clk_rd     (clk_rd),
        .FPGA_RESET (FPGA_RESET),
        .bus        (bus),
        .rx_busy    (rx_busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .cmd_mode   (cmd_mode),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk_rd = ~clk_rd;

    int cyc = 0;
    always @(posedge clk_rd) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errs   = 0;

    wr_exp_t     wr_q[$];
    ev_exp_t     ev_q[$];
    logic [15:0] run_q[$];

    logic [15:0] m_cmd_mode, m_frame_cnt, m_err_cnt;
    logic [1:0]  m_err_code;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_cmd_mode  = '0;
        m_frame_cnt = '0;
        m_err_cnt   = '0;
        m_err_code  = '0;
    endtask

    task automatic push_err(input logic [1:0] code, input int stamp);
        ev_exp_t e;
        m_err_code = code;
        if (m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 16'd1;
        e = '{is_done: 1'b0, code: m_err_code, mode: m_cmd_mode,
              fcnt: m_frame_cnt, ecnt: m_err_cnt, stamp: stamp};
        ev_q.push_back(e);
    endtask

    // Outcome of one valid run (run_q[first:$]) whose word 0 lands at edge e0.
    task automatic model_run(input int e0, input int first);
        int len;
        int n;
        ev_exp_t e;
        len = run_q.size() - first;
        if (run_q[first] != HEADER) begin
            push_err(2'b01, e0);
        end else begin
            n = (len < int'(FRAME_LEN)) ? len : int'(FRAME_LEN);
            for (int i = 0; i < n; i++)
                wr_q.push_back('{addr: i, data: run_q[first+i], stamp: e0 + i});
            if (len < int'(FRAME_LEN)) begin
                push_err(2'b10, e0 + len);
            end else if (len == int'(FRAME_LEN)) begin
                m_cmd_mode  = run_q[first+1];
                m_frame_cnt = m_frame_cnt + 16'd1;
                e = '{is_done: 1'b1, code: m_err_code, mode: m_cmd_mode,
                      fcnt: m_frame_cnt, ecnt: m_err_cnt, stamp: e0 + len};
                ev_q.push_back(e);
            end else begin
                push_err(2'b11, e0 + int'(FRAME_LEN));
            end
        end
    endtask

    task automatic build_good(input logic [15:0] mode);
        run_q.delete();
        run_q.push_back(HEADER);
        repeat (24) run_q.push_back(mode);
        repeat (156) run_q.push_back(16'h0000);
    endtask

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge clk_rd);
            bus.frame_in_valid = 1'b0;
            bus.frame_in       = 16'h0000;
        end
    endtask

    task automatic send_run();
        @(negedge clk_rd);
        model_run(cyc + 1, 0);
        for (int i = 0; i < run_q.size(); i++) begin
            if (i > 0) @(negedge clk_rd);
            bus.frame_in_valid = 1'b1;
            bus.frame_in       = run_q[i];
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},   longint'(bus.ram_wr_en),   0);
        check({tag, "_wr_addr"}, longint'(bus.ram_wr_addr), 0);
        check({tag, "_wr_data"}, longint'(bus.ram_wr_data), 0);
        check({tag, "_busy"},    longint'(rx_busy),         0);
        check({tag, "_done"},    longint'(frame_done),      0);
        check({tag, "_err"},     longint'(frame_err),       0);
        check({tag, "_code"},    longint'(err_code),        0);
        check({tag, "_mode"},    longint'(cmd_mode),        0);
        check({tag, "_fcnt"},    longint'(frame_cnt),       0);
        check({tag, "_ecnt"},    longint'(err_cnt),         0);
    endtask

    // Stream continues through a one-cycle reset pulse on word r.
    task automatic send_run_with_reset(input int r);
        int e0;
        @(negedge clk_rd);
        e0 = cyc + 1;
        for (int i = 0; i < r; i++)
            wr_q.push_back('{addr: i, data: run_q[i], stamp: e0 + i});
        for (int i = 0; i < run_q.size(); i++) begin
            if (i > 0) @(negedge clk_rd);
            if (i == r + 1) begin
                check_all_zero("midrst");
                model_reset();
                model_run(cyc + 1, r + 1);
            end
            FPGA_RESET         = (i == r);
            bus.frame_in_valid = 1'b1;
            bus.frame_in       = run_q[i];
        end
    endtask

    // Monitor: pop and compare whenever the DUT writes or pulses.
    wr_exp_t mon_w;
    ev_exp_t mon_e;
    always @(negedge clk_rd) begin
        if (bus.ram_wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write_addr", longint'(bus.ram_wr_addr), -1);
            end else begin
                mon_w = wr_q.pop_front();
                check("wr_addr",  longint'(bus.ram_wr_addr), mon_w.addr);
                check("wr_data",  longint'(bus.ram_wr_data), longint'(mon_w.data));
                check("wr_cycle", longint'(cyc), mon_w.stamp);
                check("wr_busy",  longint'(rx_busy), 1);
            end
        end
        if (frame_done === 1'b1 || frame_err === 1'b1) begin
            check("done_err_exclusive", longint'(frame_done & frame_err), 0);
            if (ev_q.size() == 0) begin
                check("unexpected_pulse_done", longint'(frame_done), -1);
            end else begin
                mon_e = ev_q.pop_front();
                check("ev_is_done", longint'(frame_done), longint'(mon_e.is_done));
                check("ev_err_code", longint'(err_code), longint'(mon_e.code));
                check("ev_cmd_mode", longint'(cmd_mode), longint'(mon_e.mode));
                check("ev_frame_cnt", longint'(frame_cnt), longint'(mon_e.fcnt));
                check("ev_err_cnt", longint'(err_cnt), longint'(mon_e.ecnt));
                check("ev_cycle", longint'(cyc), mon_e.stamp);
                check("ev_busy", longint'(rx_busy), 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int len;
        logic [15:0] w;

        FPGA_RESET         = 1'b1;
        bus.frame_in_valid = 1'b0;
        bus.frame_in       = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk_rd);
        check_all_zero("reset");
        FPGA_RESET = 1'b0;
        drive_idle(2);

        // 1: good frame
        build_good(16'h0003);
        send_run();
        drive_idle(3);
        check("t1_cmd_mode", longint'(cmd_mode), 16'h0003);
        check("t1_frame_cnt", longint'(frame_cnt), 1);
        check("t1_err_cnt", longint'(err_cnt), 0);

        // 2: header error, then a good frame
        build_good(16'h0007);
        run_q[0] = 16'h1234;
        send_run();
        drive_idle(2);
        check("t2_err_code", longint'(err_code), 2'b01);
        check("t2_cmd_mode", longint'(cmd_mode), 16'h0003);
        build_good(16'h0003);
        send_run();
        drive_idle(2);

        // 3: short frame (100 words)
        build_good(16'h0003);
        while (run_q.size() > 100) void'(run_q.pop_back());
        send_run();
        drive_idle(2);
        check("t3_err_code", longint'(err_code), 2'b10);

        // 4: long frame (185 words)
        build_good(16'h0009);
        repeat (4) run_q.push_back(16'h0001);
        send_run();
        drive_idle(2);
        check("t4_err_code", longint'(err_code), 2'b11);
        check("t4_cmd_mode", longint'(cmd_mode), 16'h0003);

        // 5: back-to-back frames with a single idle cycle
        build_good(16'h0003);
        send_run();
        drive_idle(1);
        build_good(16'h0005);
        send_run();
        drive_idle(2);
        check("t5_cmd_mode", longint'(cmd_mode), 16'h0005);

        // 6: reset at word 90, then a good frame
        build_good(16'h0003);
        send_run_with_reset(90);
        drive_idle(2);
        check("t6_err_code", longint'(err_code), 2'b01);
        build_good(16'h0004);
        send_run();
        drive_idle(2);
        check("t6_frame_cnt", longint'(frame_cnt), 1);

        // Randomized runs
        for (int t = 0; t < 30; t++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       len = int'(FRAME_LEN);
                1:       len = int'($urandom_range(1, FRAME_LEN - 1));
                2:       len = int'(FRAME_LEN) + int'($urandom_range(1, 5));
                default: len = int'(FRAME_LEN);
            endcase
            run_q.delete();
            for (int i = 0; i < len; i++) run_q.push_back(16'($urandom));
            run_q[0] = HEADER;
            if (kind == 3) begin
                w = 16'($urandom);
                if (w == HEADER) w = ~w;
                run_q[0] = w;
            end
            send_run();
            drive_idle(int'($urandom_range(1, 3)));
        end

        drive_idle(10);
        check("wr_q_drained", longint'(wr_q.size()), 0);
        check("ev_q_drained", longint'(ev_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
